// File: rtl/alu_req_pkg.sv
// Shared types and the ALU reference function for the ALU request master.
// Holds the default widths, opcode map, command struct and FSM state encoding.
package alu_req_pkg;

    localparam int WIDTH = 16;
    localparam int OP_W  = 3;

    typedef enum logic [OP_W-1:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100
    } alu_op_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OP_W-1:0]  op;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Unused opcodes (101-111) yield zero; add/sub wrap with no carry.
    function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [OP_W-1:0]  op);
        logic [WIDTH-1:0] r;
        case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            AND:     r = a & b;
            OR:      r = a | b;
            XOR:     r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
// A push while full is dropped even if a pop happens in the same cycle.
module alu_cmd_fifo
    import alu_req_pkg::*;
#(
    parameter type T     = alu_cmd_t,
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  T                           wdata,
    input  logic                       pop,
    output T                           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_req_master.sv
// Buffers ALU commands, drives them to the ALU one at a time, returns results in order.
// Optional build macro ALU_SELFCHECK_EN adds a reference check feeding rsp_mismatch.
module alu_req_master
    import alu_req_pkg::*;
#(
    parameter int WIDTH      = alu_req_pkg::WIDTH,
    parameter int OP_W       = alu_req_pkg::OP_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [OP_W-1:0]  cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [OP_W-1:0]  rsp_op,
    output logic             rsp_mismatch,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the source holds its payload stable while valid is high and ready is low.

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OP_W-1:0]  op;
    } cmd_t;

    state_e                        state;
    cmd_t                          push_cmd;
    cmd_t                          head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;
    logic                          push;
    logic                          pop;
    logic                          mismatch_d;

    assign push_cmd  = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    alu_cmd_fifo #(
        .T     (cmd_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef ALU_SELFCHECK_EN
    logic [WIDTH-1:0] expected;
    assign expected   = alu_ref(alu_a, alu_b, alu_op);
    assign mismatch_d = (alu_result != expected);
`else
    assign mismatch_d = 1'b0;
`endif

    // DRIVE lasts exactly one cycle so the combinational ALU settles before capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_op       <= '0;
            rsp_mismatch <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_a  <= head.a;
                        alu_b  <= head.b;
                        alu_op <= head.op;
                        state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    rsp_result   <= alu_result;
                    rsp_op       <= alu_op;
                    rsp_mismatch <= mismatch_d;
                    rsp_valid    <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        rsp_mismatch <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_master.sv
// Self-checking bench for alu_req_master: directed latency/backpressure/reset cases
// plus randomized traffic scored against an in-order queue of expected responses.
module tb_alu_req_master;

    localparam int W  = 16;
    localparam int OW = 3;
    localparam int SW = W + OW + 1;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [OW-1:0] cmd_op;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [OW-1:0] alu_op;
    logic [W-1:0]  alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    logic [OW-1:0] rsp_op;
    logic          rsp_mismatch;
    logic          busy;

    logic          alu_fault;
    logic          rdy_rand;
    int            n_checks;
    int            n_fail;
    int            n_rsp;
    logic [SW-1:0] exp_q[$];

    alu_req_master dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_op       (rsp_op),
        .rsp_mismatch (rsp_mismatch),
        .busy         (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required to finish");
        $fatal(1, "timeout");
    end

    // ---------------- ALU model ----------------
    function automatic logic [W-1:0] model_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [OW-1:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign alu_result = model_alu(alu_a, alu_b, alu_op) + W'(alu_fault);

    function automatic logic [SW-1:0] pack_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [OW-1:0] op);
        logic [W-1:0] r;
        logic         mm;
        r = model_alu(a, b, op) + W'(alu_fault);
`ifdef ALU_SELFCHECK_EN
        mm = alu_fault;
`else
        mm = 1'b0;
`endif
        return {mm, op, r};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic          prev_vld;
    logic [W-1:0]  prev_res;
    logic [OW-1:0] prev_op;
    logic [SW-1:0] e;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_vld = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) exp_q.push_back(pack_exp(cmd_a, cmd_b, cmd_op));
            if (prev_vld) begin
                check("rsp_held_valid", 32'(rsp_valid), 32'd1);
                check("rsp_held_result", 32'(rsp_result), 32'(prev_res));
                check("rsp_held_op", 32'(rsp_op), 32'(prev_op));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", 32'(rsp_result), 32'(e[W-1:0]));
                    check("rsp_op", 32'(rsp_op), 32'(e[W+OW-1:W]));
                    check("rsp_mismatch", 32'(rsp_mismatch), 32'(e[SW-1]));
                    n_rsp++;
                end
                prev_vld = 1'b0;
            end else begin
                prev_vld = rsp_valid;
                prev_res = rsp_result;
                prev_op  = rsp_op;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_rand) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op);
        logic acc;
        acc       = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            acc = cmd_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy && !rsp_valid && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    int   n_acc;
    int   rsp_before;
    logic seen;
    logic [W-1:0] held;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_rsp     = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        rsp_ready = 1'b1;
        alu_fault = 1'b0;
        rdy_rand  = 1'b0;
        prev_vld  = 1'b0;
        tick(3);
        check_reset_state("reset");
        check("reset_rsp_result", 32'(rsp_result), 32'd0);
        check("reset_rsp_mismatch", 32'(rsp_mismatch), 32'd0);
        rst = 1'b0;
        tick(2);

        // Single ADD with cycle-exact latency
        send(16'h0003, 16'h0004, 3'd0);
        check("lat_n_rsp_valid", 32'(rsp_valid), 32'd0);
        check("lat_n_busy", 32'(busy), 32'd1);
        tick(1);
        check("lat_n1_alu_a", 32'(alu_a), 32'h3);
        check("lat_n1_alu_b", 32'(alu_b), 32'h4);
        check("lat_n1_alu_op", 32'(alu_op), 32'd0);
        check("lat_n1_rsp_valid", 32'(rsp_valid), 32'd0);
        tick(1);
        check("lat_n2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("lat_n2_rsp_result", 32'(rsp_result), 32'h7);
        check("lat_n2_rsp_op", 32'(rsp_op), 32'd0);
        tick(1);
        check("lat_n3_rsp_valid", 32'(rsp_valid), 32'd0);
        wait_idle();

        // Wrap-around and unused opcode
        send(16'h0000, 16'h0001, 3'd1);
        send(16'hFFFF, 16'h0001, 3'd0);
        send(16'h1234, 16'h5678, 3'd5);
        wait_idle();

        // Randomized traffic with random downstream stalls
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
        end
        rdy_rand = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        // Backpressure: 1 in flight + 4 queued, then full
        rsp_ready  = 1'b0;
        n_acc      = 0;
        rsp_before = n_rsp;
        for (int i = 0; i < 7; i++) begin
            cmd_a     = 16'(16'h0100 + i);
            cmd_b     = 16'(i);
            cmd_op    = 3'(i % 5);
            cmd_valid = 1'b1;
            if (cmd_ready) n_acc++;
            tick(1);
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(n_acc), 32'd5);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        held = rsp_result;
        tick(5);
        check("bp_result_held", 32'(rsp_result), 32'(held));
        check("bp_still_full", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        wait_idle();
        check("bp_rsp_count", 32'(n_rsp - rsp_before), 32'd5);
        check("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);

        // Reset mid-operation: one response pending, three queued
        rsp_ready = 1'b0;
        send(16'h0011, 16'h0022, 3'd0);
        send(16'h0033, 16'h0044, 3'd1);
        send(16'h0055, 16'h0066, 3'd2);
        send(16'h0077, 16'h0088, 3'd3);
        check("rstmid_rsp_valid_before", 32'(rsp_valid), 32'd1);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("rstmid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | rsp_valid | busy;
        end
        check("rstmid_no_stale", 32'(seen), 32'd0);

        // Faulty ALU then correct ALU
        alu_fault = 1'b1;
        send(16'h0001, 16'h0001, 3'd0);
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) break;
            tick(1);
        end
        check("fault_rsp_valid", 32'(rsp_valid), 32'd1);
        check("fault_rsp_result", 32'(rsp_result), 32'h3);
`ifdef ALU_SELFCHECK_EN
        check("fault_mismatch", 32'(rsp_mismatch), 32'd1);
`else
        check("fault_mismatch", 32'(rsp_mismatch), 32'd0);
`endif
        wait_idle();
        alu_fault = 1'b0;
        send(16'h0001, 16'h0001, 3'd0);
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) break;
            tick(1);
        end
        check("good_rsp_result", 32'(rsp_result), 32'h2);
        check("good_mismatch", 32'(rsp_mismatch), 32'd0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_req_master.md
Name: alu_req_master

Overview:
Initiator for the 16-bit combinational ALU. It accepts operation commands (A, B, op) from an upstream valid/ready stream and buffers them in a small FIFO. It drives each command onto the ALU operand and opcode inputs, captures the ALU result after a fixed settle cycle, and returns it on a downstream valid/ready response stream in strict command order. It sits between a command source (sequencer or CPU-side logic) and the ALU instance.

Parameters:
WIDTH, 16, operand and result width
OP_W, 3, opcode width
FIFO_DEPTH, 4, command FIFO entries (power of two, >= 2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  upstream command valid
cmd_ready  out  1  upstream ready; = FIFO not full
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_op  in  OP_W  opcode
alu_a  out  WIDTH  registered operand A to ALU
alu_b  out  WIDTH  registered operand B to ALU
alu_op  out  OP_W  registered opcode to ALU
alu_result  in  WIDTH  combinational ALU result
rsp_valid  out  1  response valid
rsp_ready  in  1  downstream ready
rsp_result  out  WIDTH  captured result
rsp_op  out  OP_W  opcode of the response
rsp_mismatch  out  1  self-check flag (see Optional Feature)
busy  out  1  state != IDLE or FIFO not empty

Behaviour:
- Reset (async, immediate): FIFO flushed; state = IDLE; alu_a, alu_b, alu_op, rsp_result, rsp_op, rsp_mismatch = 0; rsp_valid = 0; busy = 0; cmd_ready = 1.
- Pushes are ignored while rst is high.
- Push: a command is pushed on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready = !full, a registered-count decode.
  - When full, no push is accepted even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count is unchanged.
- No bypass: a command always enters the FIFO first.
- FSM states: IDLE, DRIVE, RESP.
  - IDLE: if FIFO is non-empty, pop the head into alu_a/alu_b/alu_op and go to DRIVE. Otherwise stay; alu_* hold their last values.
  - DRIVE: exactly one cycle for the ALU to settle. At the end of the cycle, capture alu_result into rsp_result and alu_op into rsp_op, set rsp_valid = 1, and go to RESP.
  - RESP: rsp_valid, rsp_result and rsp_op are held stable until rsp_valid && rsp_ready. On that handshake edge, rsp_valid is cleared and the FSM goes to IDLE.
- Latency: command accepted at edge N into an empty, idle block → alu_* valid after N+1 → rsp_valid high after N+2. Minimum issue interval is 3 cycles per command.
- Ordering: responses are returned strictly in acceptance order; no command is dropped or duplicated.
- Opcode map (informational; implemented by the ALU): 000 add, 001 sub, 010 and, 011 or, 100 xor, 101–111 result 0. Add and sub wrap modulo 2^WIDTH with no carry output.
- Reset mid-operation: all queued and in-flight commands are discarded and rsp_valid drops asynchronously. No stale response appears after reset release.

Optional Feature:
ALU_SELFCHECK_EN
- Defined: in DRIVE, an internal reference computes the expected result from alu_a/alu_b/alu_op using the opcode map above. rsp_mismatch is registered alongside rsp_result (1 if alu_result != expected) and is valid while rsp_valid is high. It clears on the response handshake.
- Undefined: no reference logic is built and rsp_mismatch is tied to 0. The port list is identical in both builds.

Decomposition:
- Package alu_req_pkg:
  - WIDTH and OP_W defaults
  - alu_op_e enum (ADD, SUB, AND, OR, XOR)
  - alu_cmd_t packed struct {a, b, op}
  - fsm state enum
  - function alu_ref(a, b, op), used by the self-check and the bench
- One sub-module: alu_cmd_fifo (parameterised sync FIFO of alu_cmd_t, with full, empty and count).

Test Plan:
- Reset: assert rst mid-cycle → rsp_valid=0, alu_a/alu_b/alu_op=0, busy=0, cmd_ready=1 immediately.
- Single ADD: A=16'h0003, B=16'h0004, op=000, rsp_ready=1 → rsp_result=16'h0007, rsp_op=000. rsp_valid rises 2 edges after acceptance and stays high one cycle.
- Wrap-around: SUB 16'h0000−16'h0001 → 16'hFFFF. ADD 16'hFFFF+16'h0001 → 16'h0000. Opcode 101 with A=16'h1234 → 16'h0000.
- Backpressure: rsp_ready=0, offer 7 back-to-back commands.
  - Expected: 5 accepted (1 in flight, 4 queued), then cmd_ready=0.
  - rsp_result held stable throughout.
  - Release rsp_ready → 5 responses in order, then cmd_ready=1.
- Reset mid-operation: 3 commands queued and one in RESP, pulse rst → rsp_valid drops at once; no responses after release; busy=0.
- ALU_SELFCHECK_EN with a faulty ALU model returning A+B+1: ADD 16'h0001+16'h0001 → rsp_result=16'h0003, rsp_mismatch=1. With the correct ALU → rsp_mismatch=0.
